mppt_seq: RTL and testbench
===========================

MPPT_SEQ -- requirements
Module: mppt_seq

Interface
REQ-001 Parameter PERIOD_W, default 16: width of the inter-iteration wait period.
REQ-002 Parameter TMO, default 63: maximum cycles spent in CONV awaiting conv_done.
REQ-003 clk  in  1  single system clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset; asynchronous, active-low.
REQ-005 run  in  1  level; 1 = keep iterating the MPPT loop, 0 = stop after the current iteration.
REQ-006 period  in  PERIOD_W  wait cycles between iterations; sampled on entry to WAIT.
REQ-007 conv_done  in  1  one-cycle pulse from the ADC: V/I samples are valid.
REQ-008 conv_req  out  1  level conversion request to the ADC.
REQ-009 en  out  4  one-hot stage strobes to the datapath: [0] latch V/I, [1] compute power, [2] P&O decision, [3] duty update.
REQ-010 busy  out  1  1 in every state except IDLE.
REQ-011 tmo_err  out  1  sticky conversion-timeout flag.
REQ-012 iter_cnt  out  8  count of completed iterations.

Function
REQ-013 FSM states SHALL be IDLE, CONV, LATCH, CALC, DECIDE, UPDATE, WAIT; conv_req, en and busy SHALL be Moore outputs decoded from the registered state.
REQ-014 IDLE: run=1 -> CONV, clear tmo_err and timeout counter; else stay.
REQ-015 CONV: conv_req=1; conv_done=1 -> LATCH; timeout counter reaching TMO without conv_done -> set tmo_err, go to WAIT, skip LATCH..UPDATE.
REQ-016 LATCH, CALC, DECIDE, UPDATE SHALL each last exactly one cycle, asserting en = 0001, 0010, 0100, 1000 respectively, in that order.
REQ-017 en SHALL be 0000 in IDLE, CONV and WAIT; at most one en bit SHALL be high in any cycle.
REQ-018 UPDATE -> WAIT unconditionally; iter_cnt SHALL increment on leaving UPDATE and wrap 255 -> 0.
REQ-019 WAIT: the down-counter SHALL load period on entry and exit when it reaches 0; period=0 SHALL give a WAIT of one cycle; WAIT lasts max(period,1) cycles.
REQ-020 On WAIT exit: run=1 -> CONV with the timeout counter cleared; run=0 -> IDLE.
REQ-021 run falling in CONV..UPDATE SHALL NOT abort the iteration; the sequence completes through WAIT, then goes to IDLE.
REQ-022 conv_done outside CONV SHALL be ignored.
REQ-023 conv_done arriving on the same cycle the timeout count reaches TMO SHALL win: -> LATCH, tmo_err unchanged.
REQ-024 tmo_err SHALL stay set until the next IDLE -> CONV transition or reset.
REQ-025 Latency: conv_done sampled high at edge n SHALL give en[0]=1 for the cycle following edge n and conv_req=0 from edge n.

Reset
REQ-026 rst_n=0 SHALL asynchronously force state=IDLE, conv_req=0, en=0000, busy=0, tmo_err=0, iter_cnt=0, and clear the wait and timeout counters.
REQ-027 Reset asserted mid-iteration SHALL abandon the iteration with no further en strobes.
REQ-028 After rst_n deasserts, the first transition SHALL occur on the next rising clk edge with run=1.

Structure
REQ-029 A shared package SHALL hold the state enumeration, the en bit-index constants (EN_LATCH=0, EN_CALC=1, EN_DECIDE=2, EN_UPDATE=3) and the default PERIOD_W/TMO values.
REQ-030 The wait and timeout counting SHALL live in one sub-module, mppt_tmr, a loadable down-counter with a zero flag, instantiated twice.

Verification
REQ-031 Reset, run=1, period=4, conv_done 3 cycles after conv_req rises -> en sequence 0001,0010,0100,1000 on consecutive cycles, 4 WAIT cycles, conv_req high again, iter_cnt=1.
REQ-032 run=1, conv_done never asserted -> after 63 CONV cycles tmo_err=1, no en pulses, WAIT, retry CONV; tmo_err remains 1.
REQ-033 run dropped during CALC -> DECIDE and UPDATE still strobe, WAIT completes, IDLE, busy=0, iter_cnt increments once.
REQ-034 period=0 and 256 back-to-back iterations -> each WAIT is 1 cycle, iter_cnt wraps to 0.
REQ-035 rst_n asserted during DECIDE -> outputs zero immediately without a clock edge; no en[3] pulse follows.
REQ-036 conv_done pulsed in WAIT and IDLE -> ignored; conv_done on the exact TMO cycle -> LATCH with tmo_err=0.

Source files
------------

// File: rtl/mppt_seq_pkg.sv
// mppt_seq_pkg
// Shared definitions for the MPPT iteration sequencer: FSM state encoding,
// bit positions of the datapath stage strobes, and default parameter values.
package mppt_seq_pkg;

  localparam int PERIOD_W_DEF = 16;
  localparam int TMO_DEF      = 63;

  // Bit positions inside the en[3:0] stage-strobe bus.
  localparam int EN_LATCH  = 0;
  localparam int EN_CALC   = 1;
  localparam int EN_DECIDE = 2;
  localparam int EN_UPDATE = 3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CONV   = 3'd1,
    S_LATCH  = 3'd2,
    S_CALC   = 3'd3,
    S_DECIDE = 3'd4,
    S_UPDATE = 3'd5,
    S_WAIT   = 3'd6
  } state_t;

endpackage

// File: rtl/mppt_seq_tmr.sv
// mppt_tmr
// Loadable down-counter with a zero flag. Used once for the inter-iteration
// wait and once for the conversion timeout.
// Ports:
//   clk, rst_n  clock / async active-low reset (count cleared to 0)
//   load        load load_val this cycle (takes priority over dec)
//   load_val    value to load
//   dec         decrement by one; holds at 0
//   zero        count == 0
module mppt_tmr #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mppt_seq.sv
// mppt_seq
// Sequencer for one perturb-and-observe MPPT iteration:
//   IDLE -> CONV (ADC request) -> LATCH -> CALC -> DECIDE -> UPDATE -> WAIT
// and back to CONV while run stays high, or to IDLE once it drops.
// Ports:
//   clk, rst_n  clock / async active-low reset
//   run         keep iterating (level); a drop finishes the current iteration
//   period      WAIT length in cycles, sampled on entry to WAIT (0 acts as 1)
//   conv_done   ADC samples valid (1-cycle pulse), only honoured in CONV
//   conv_req    ADC conversion request (high throughout CONV)
//   en          one-hot stage strobes {UPDATE, DECIDE, CALC, LATCH}
//   busy        high in every state except IDLE
//   tmo_err     sticky conversion timeout, cleared on IDLE -> CONV
//   iter_cnt    completed iterations, wraps at 255
//   state_dbg   registered FSM state, for observation only
// Handshake: conv_req is a level held for the whole of CONV; the ADC answers
// with a single-cycle conv_done. No back-pressure exists on en: each strobe is
// high for exactly one cycle and the datapath must accept it.
module mppt_seq
  import mppt_seq_pkg::*;
#(
  parameter int PERIOD_W = PERIOD_W_DEF,
  parameter int TMO      = TMO_DEF       // must be >= 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic [PERIOD_W-1:0] period,
  input  logic                conv_done,
  output logic                conv_req,
  output logic [3:0]          en,
  output logic                busy,
  output logic                tmo_err,
  output logic [7:0]          iter_cnt,
  output logic [2:0]          state_dbg
);

  // The timeout counter is loaded with TMO-1 on CONV entry, so the zero flag
  // is seen in the TMO-th CONV cycle; CONV therefore lasts at most TMO cycles.
  localparam int TMO_W = (TMO < 2) ? 1 : $clog2(TMO);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TMO - 1);

  state_t state, state_nxt;

  logic                wait_load, wait_zero;
  logic [PERIOD_W-1:0] wait_val;
  logic                tmo_load, tmo_zero;
  logic                tmo_hit;

  // Timeout fires only when conv_done is absent in the final CONV cycle.
  assign tmo_hit = (state == S_CONV) && !conv_done && tmo_zero;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (run) state_nxt = S_CONV;
      S_CONV: begin
        if (conv_done)     state_nxt = S_LATCH;
        else if (tmo_zero) state_nxt = S_WAIT;
      end
      S_LATCH:  state_nxt = S_CALC;
      S_CALC:   state_nxt = S_DECIDE;
      S_DECIDE: state_nxt = S_UPDATE;
      S_UPDATE: state_nxt = S_WAIT;
      S_WAIT:   if (wait_zero) state_nxt = run ? S_CONV : S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the registered state.
  always_comb begin
    conv_req = 1'b0;
    en       = 4'b0000;
    busy     = 1'b1;
    case (state)
      S_IDLE:   busy = 1'b0;
      S_CONV:   conv_req = 1'b1;
      S_LATCH:  en[EN_LATCH]  = 1'b1;
      S_CALC:   en[EN_CALC]   = 1'b1;
      S_DECIDE: en[EN_DECIDE] = 1'b1;
      S_UPDATE: en[EN_UPDATE] = 1'b1;
      default:  ;
    endcase
  end

  assign state_dbg = state;

  // Counters are (re)loaded on the transition into their state.
  assign tmo_load  = (state != S_CONV) && (state_nxt == S_CONV);
  assign wait_load = (state != S_WAIT) && (state_nxt == S_WAIT);
  assign wait_val  = (period == '0) ? '0 : period - PERIOD_W'(1);

  mppt_tmr #(.W(PERIOD_W)) u_wait_tmr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (wait_load),
    .load_val (wait_val),
    .dec      (state == S_WAIT),
    .zero     (wait_zero)
  );

  mppt_tmr #(.W(TMO_W)) u_tmo_tmr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmo_load),
    .load_val (TMO_LOAD),
    .dec      (state == S_CONV),
    .zero     (tmo_zero)
  );

  // Sticky timeout flag and iteration counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_err  <= 1'b0;
      iter_cnt <= 8'd0;
    end else begin
      if ((state == S_IDLE) && run) begin
        tmo_err <= 1'b0;
      end else if (tmo_hit) begin
        tmo_err <= 1'b1;
      end
      if (state == S_UPDATE) begin
        iter_cnt <= iter_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_mppt_seq.sv
// tb_mppt_seq
// Directed bench for mppt_seq (PERIOD_W=16, TMO=63). Inputs are driven and
// outputs sampled on the falling clock edge, away from the active edge.
module tb_mppt_seq;
  import mppt_seq_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic [15:0] period;
  logic        conv_done;
  logic        conv_req;
  logic [3:0]  en;
  logic        busy;
  logic        tmo_err;
  logic [7:0]  iter_cnt;
  logic [2:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  mppt_seq #(.PERIOD_W(16), .TMO(63)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .period    (period),
    .conv_done (conv_done),
    .conv_req  (conv_req),
    .en        (en),
    .busy      (busy),
    .tmo_err   (tmo_err),
    .iter_cnt  (iter_cnt),
    .state_dbg (state_dbg)
  );

  // Clock / reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; period = 16'd4; conv_done = 1'b0;
    step(2);

    // Reset state.
    chk("rst_state", 32'(state_dbg), 32'(S_IDLE));
    chk("rst_conv_req", 32'(conv_req), 32'd0);
    chk("rst_en", 32'(en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tmo_err", 32'(tmo_err), 32'd0);
    chk("rst_iter", 32'(iter_cnt), 32'd0);

    // Basic iteration: period=4, conv_done 3 cycles after conv_req rises.
    rst_n = 1'b1; run = 1'b1;
    step(1);
    chk("first_conv", 32'(state_dbg), 32'(S_CONV));
    chk("first_conv_req", 32'(conv_req), 32'd1);
    chk("first_busy", 32'(busy), 32'd1);
    step(2);
    chk("conv_hold_req", 32'(conv_req), 32'd1);
    chk("conv_hold_en", 32'(en), 32'd0);
    conv_done = 1'b1;
    step(1);
    conv_done = 1'b0;
    chk("b_latch_en", 32'(en), 32'b0001);
    chk("b_latch_req", 32'(conv_req), 32'd0);
    step(1); chk("b_calc_en", 32'(en), 32'b0010);
    step(1); chk("b_decide_en", 32'(en), 32'b0100);
    step(1); chk("b_update_en", 32'(en), 32'b1000);
    chk("b_update_iter", 32'(iter_cnt), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("b_wait_state", 32'(state_dbg), 32'(S_WAIT));
      chk("b_wait_en", 32'(en), 32'd0);
    end
    chk("b_wait_iter", 32'(iter_cnt), 32'd1);
    step(1);
    chk("b_reconv", 32'(state_dbg), 32'(S_CONV));
    chk("b_reconv_req", 32'(conv_req), 32'd1);

    // run dropped during CALC; conv_done in WAIT and IDLE ignored.
    conv_done = 1'b1;
    step(1);
    conv_done = 1'b0;
    chk("d_latch_en", 32'(en), 32'b0001);
    step(1);
    chk("d_calc_en", 32'(en), 32'b0010);
    run = 1'b0;
    step(1); chk("d_decide_en", 32'(en), 32'b0100);
    step(1); chk("d_update_en", 32'(en), 32'b1000);
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("d_wait_state", 32'(state_dbg), 32'(S_WAIT));
      conv_done = (i == 0);
    end
    conv_done = 1'b0;
    step(1);
    chk("d_idle_state", 32'(state_dbg), 32'(S_IDLE));
    chk("d_idle_busy", 32'(busy), 32'd0);
    chk("d_idle_iter", 32'(iter_cnt), 32'd2);
    conv_done = 1'b1;
    step(1);
    conv_done = 1'b0;
    chk("idle_ignore_state", 32'(state_dbg), 32'(S_IDLE));
    chk("idle_ignore_en", 32'(en), 32'd0);

    // Timeout: conv_done never arrives, 63 CONV cycles then WAIT, retry.
    period = 16'd2; run = 1'b1;
    step(1);
    chk("t_conv", 32'(state_dbg), 32'(S_CONV));
    chk("t_tmo_clear", 32'(tmo_err), 32'd0);
    for (int i = 0; i < 62; i++) begin
      step(1);
      chk("t_conv_hold", 32'(state_dbg), 32'(S_CONV));
      chk("t_conv_en", 32'(en), 32'd0);
    end
    chk("t_tmo_pending", 32'(tmo_err), 32'd0);
    step(1);
    chk("t_wait", 32'(state_dbg), 32'(S_WAIT));
    chk("t_tmo_set", 32'(tmo_err), 32'd1);
    chk("t_wait_en", 32'(en), 32'd0);
    step(1); chk("t_wait2", 32'(state_dbg), 32'(S_WAIT));
    step(1);
    chk("t_retry", 32'(state_dbg), 32'(S_CONV));
    chk("t_tmo_sticky", 32'(tmo_err), 32'd1);
    chk("t_iter", 32'(iter_cnt), 32'd2);

    // conv_done on the exact TMO cycle with tmo_err already set.
    run = 1'b0;
    step(62);
    conv_done = 1'b1;
    step(1);
    conv_done = 1'b0;
    chk("x1_latch_en", 32'(en), 32'b0001);
    chk("x1_tmo_kept", 32'(tmo_err), 32'd1);
    step(3); chk("x1_update_en", 32'(en), 32'b1000);
    step(1); chk("x1_iter", 32'(iter_cnt), 32'd3);
    step(2); chk("x1_idle", 32'(state_dbg), 32'(S_IDLE));

    // conv_done on the exact TMO cycle after a fresh IDLE -> CONV.
    run = 1'b1;
    step(1);
    chk("x2_conv", 32'(state_dbg), 32'(S_CONV));
    chk("x2_tmo_clear", 32'(tmo_err), 32'd0);
    step(62);
    chk("x2_last_conv", 32'(state_dbg), 32'(S_CONV));
    conv_done = 1'b1;
    step(1);
    conv_done = 1'b0;
    run = 1'b0;
    chk("x2_latch_en", 32'(en), 32'b0001);
    chk("x2_tmo_zero", 32'(tmo_err), 32'd0);
    step(3); chk("x2_update_en", 32'(en), 32'b1000);
    step(1); chk("x2_iter", 32'(iter_cnt), 32'd4);
    step(2); chk("x2_idle", 32'(state_dbg), 32'(S_IDLE));

    // Reset asserted during DECIDE.
    period = 16'd0; run = 1'b1;
    step(1);
    conv_done = 1'b1;
    step(1);
    conv_done = 1'b0;
    step(2);
    chk("r_decide_en", 32'(en), 32'b0100);
    #2 rst_n = 1'b0;
    #1;
    chk("r_async_en", 32'(en), 32'd0);
    chk("r_async_busy", 32'(busy), 32'd0);
    chk("r_async_req", 32'(conv_req), 32'd0);
    chk("r_async_iter", 32'(iter_cnt), 32'd0);
    chk("r_async_state", 32'(state_dbg), 32'(S_IDLE));
    run = 1'b0;
    step(3);
    chk("r_hold_en", 32'(en), 32'd0);
    rst_n = 1'b1;
    step(1);
    chk("r_after_idle", 32'(state_dbg), 32'(S_IDLE));

    // period=0, 256 back-to-back iterations: 1-cycle WAIT, iter_cnt wraps.
    run = 1'b1;
    step(1);
    for (int i = 0; i < 256; i++) begin
      chk("w_conv", 32'(state_dbg), 32'(S_CONV));
      conv_done = 1'b1;
      step(1);
      conv_done = 1'b0;
      chk("w_latch_en", 32'(en), 32'b0001);
      step(3);
      chk("w_update_en", 32'(en), 32'b1000);
      step(1);
      chk("w_wait", 32'(state_dbg), 32'(S_WAIT));
      chk("w_iter", 32'(iter_cnt), 32'((i + 1) % 256));
      step(1);
    end
    chk("w_final_conv", 32'(state_dbg), 32'(S_CONV));
    chk("w_wrapped", 32'(iter_cnt), 32'd0);
    run = 1'b0;

    // Final report.
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
